palette_ram_lut: RTL and testbench
==================================

// Module: palette_ram_lut
// PURPOSE
//  Writable, parametrised successor to the fixed PPU palette ROM. Maps {plane, palette, colour index} to a system colour.
//  Sits between the pixel mux and the video DAC stage, with a 2-stage lookup pipeline and a CPU read/write port.
//  NES-style backdrop mirroring: colour index 0 always resolves to the shared backdrop entry.
//  Self-initialising after reset via an internal init sequencer.
// PARAMETERS
//  PAL_BITS    2      palette-select width; 2**PAL_BITS palettes per plane
//  IDX_BITS    2      colour-index width; 2**IDX_BITS entries per palette
//  COLOR_W     6      system colour width
//  INIT_COLOR  6'h0F  value written to every entry during init
//  ADDR_W      1+PAL_BITS+IDX_BITS (derived, localparam)
// PORTS
//  clk              in   1         system clock
//  rst              in   1         synchronous, active-high reset
//  lk_valid         in   1         lookup request valid
//  lk_fg            in   1         1 = sprite plane, 0 = background plane
//  lk_pal           in   PAL_BITS  palette number
//  lk_idx           in   IDX_BITS  colour number within palette
//  out_valid        out  1         lookup result valid (2 cycles after lk_valid)
//  out_color        out  COLOR_W   resolved system colour
//  out_transparent  out  1         1 when lk_idx was 0 (pixel is backdrop/transparent)
//  cpu_we           in   1         palette write strobe
//  cpu_re           in   1         palette read strobe
//  cpu_addr         in   ADDR_W    {plane, pal, idx}
//  cpu_wdata        in   COLOR_W   write data
//  cpu_rdata        out  COLOR_W   read data, registered
//  cpu_rvalid       out  1         1-cycle pulse, cycle after accepted cpu_re
//  busy             out  1         init sequence in progress
// BEHAVIOUR
//  Reset: all outputs 0 except busy=1; FSM -> INIT, init counter = 0. Any rst pulse mid-operation restarts INIT and flushes the pipeline.
//  FSM INIT: writes INIT_COLOR to entry[cnt], cnt++ each cycle. After entry 2**ADDR_W-1 -> RUN (busy=0 the next cycle; 2**ADDR_W cycles total).
//  FSM RUN: terminal until rst.
//  While busy: lk_valid ignored (out_valid=0); cpu_we/cpu_re dropped (no write, no rvalid).
//  Address map, applied to both the lookup and the CPU port: if idx==0 then eff_addr = 0 (shared backdrop), else {plane, pal, idx}.
//   All writes to any {x, y, 0} alias to entry 0.
//  Lookup pipeline:
//   S1 registers eff_addr, the RAM read, and the valid/transparent flags.
//   S2 registers out_color, out_valid, out_transparent.
//   Fully pipelined, 1 lookup/cycle, no stall. out_transparent = (lk_idx==0) for either plane.
//  Simultaneous cpu_we and lookup/cpu_re to the same eff_addr in the same cycle: read returns OLD data (read-before-write); the new value is visible from the next request.
//  cpu_we and cpu_re in the same cycle are both accepted; cpu_rdata is pre-write data.
//  cpu_rdata holds its last value when cpu_rvalid=0.
// CONFIGURATION
//  PAL_GRAYSCALE_EN defined:
//   adds input gray (1b), sampled with the lookup in S1.
//   When set, S2 forces out_color[3:0]=0 and keeps the upper bits (PPU mask greyscale). Applies only to lookups, not cpu_rdata.
//  PAL_GRAYSCALE_EN undefined: no gray port; out_color = RAM data unmodified.
// STRUCTURE
//  palette_pkg: PAL_BITS/IDX_BITS/COLOR_W defaults, INIT_COLOR, function pal_eff_addr(plane,pal,idx), FSM state typedef {INIT, RUN}.
//  Sub-module palette_init_fsm: owns state, init counter, busy, and init write-port signals. The top level muxes them onto the RAM write port.
//  RAM: 2**ADDR_W x COLOR_W. Two read ports (lookup, CPU) and one write port; inferred distributed/block RAM.
// TESTING
//  1. rst 1 cycle -> busy=1 for exactly 32 cycles (defaults). Then every cpu_re returns 6'h0F.
//  2. After init, cpu_we addr 5'b1_01_10 data 6'h2A; lookup fg=1 pal=1 idx=2 -> out_color=6'h2A, out_transparent=0, 2 cycles after lk_valid.
//  3. cpu_we addr 5'b1_11_00 data 6'h21 -> cpu_re addr 5'b0_00_00 returns 6'h21. Lookup fg=0 pal=2 idx=0 -> 6'h21, out_transparent=1.
//  4. Same cycle: cpu_we entry 5'b0_10_01 <= 6'h16, lookup of the same entry -> old value. A lookup next cycle -> 6'h16.
//  5. Back-to-back lookups every cycle for 64 cycles, random stimulus -> outputs match the model with 2-cycle latency, no bubbles.
//  6. rst asserted mid-init and mid-RUN -> out_valid=0, busy=1, full re-init; writes during busy are discarded.
//  7. (PAL_GRAYSCALE_EN) entry = 6'h27, gray=1 -> out_color = 6'h20.

Source files
------------

// File: rtl/palette_ram_lut_pkg.sv
// Shared widths, init value, FSM state type and the backdrop-mirroring address map for palette_ram_lut.
// Optional feature macro used by this block: PAL_GRAYSCALE_EN.
package palette_ram_lut_pkg;

  localparam int unsigned PAL_BITS  = 2;
  localparam int unsigned IDX_BITS  = 2;
  localparam int unsigned COLOR_W   = 6;
  localparam int unsigned ADDR_W    = 1 + PAL_BITS + IDX_BITS;
  localparam int unsigned DEPTH     = 2 ** ADDR_W;
  localparam int unsigned GRAY_LSBS = 4;

  localparam logic [COLOR_W-1:0] INIT_COLOR = COLOR_W'(6'h0F);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic               valid;
    logic               transparent;
    logic [COLOR_W-1:0] color;
  } lk_result_t;

  // Colour index 0 of every palette on both planes mirrors the shared backdrop entry.
  function automatic logic [ADDR_W-1:0] pal_eff_addr(input logic                plane,
                                                     input logic [PAL_BITS-1:0] pal,
                                                     input logic [IDX_BITS-1:0] idx);
    return (idx == '0) ? '0 : {plane, pal, idx};
  endfunction

endpackage

// File: rtl/palette_ram_lut_if.sv
// Lookup, CPU and status signals of palette_ram_lut; gray exists only with PAL_GRAYSCALE_EN.
interface palette_ram_lut_if;
  import palette_ram_lut_pkg::*;

  logic                lk_valid;
  logic                lk_fg;
  logic [PAL_BITS-1:0] lk_pal;
  logic [IDX_BITS-1:0] lk_idx;
  logic                out_valid;
  logic [COLOR_W-1:0]  out_color;
  logic                out_transparent;
  logic                cpu_we;
  logic                cpu_re;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [COLOR_W-1:0]  cpu_wdata;
  logic [COLOR_W-1:0]  cpu_rdata;
  logic                cpu_rvalid;
  logic                busy;
`ifdef PAL_GRAYSCALE_EN
  logic                gray;

  modport master (output lk_valid, lk_fg, lk_pal, lk_idx, gray, cpu_we, cpu_re, cpu_addr, cpu_wdata,
                  input  out_valid, out_color, out_transparent, cpu_rdata, cpu_rvalid, busy);
  modport slave  (input  lk_valid, lk_fg, lk_pal, lk_idx, gray, cpu_we, cpu_re, cpu_addr, cpu_wdata,
                  output out_valid, out_color, out_transparent, cpu_rdata, cpu_rvalid, busy);
`else
  modport master (output lk_valid, lk_fg, lk_pal, lk_idx, cpu_we, cpu_re, cpu_addr, cpu_wdata,
                  input  out_valid, out_color, out_transparent, cpu_rdata, cpu_rvalid, busy);
  modport slave  (input  lk_valid, lk_fg, lk_pal, lk_idx, cpu_we, cpu_re, cpu_addr, cpu_wdata,
                  output out_valid, out_color, out_transparent, cpu_rdata, cpu_rvalid, busy);
`endif
endinterface

// File: rtl/palette_ram_lut_init_fsm.sv
// Post-reset init sequencer: sweeps every palette entry with INIT_COLOR, then parks in RUN.
module palette_ram_lut_init_fsm
  import palette_ram_lut_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic               busy_o,
  output logic               init_we_o,
  output logic [ADDR_W-1:0]  init_addr_o,
  output logic [COLOR_W-1:0] init_data_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // busy_q tracks "state is INIT", so it doubles as the registered init write enable.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = (state_d == ST_INIT);
    if (state_q == ST_INIT) cnt_d = ADDR_W'(cnt_q + 1'b1);
  end

  assign busy_o      = busy_q;
  assign init_we_o   = busy_q;
  assign init_addr_o = cnt_q;
  assign init_data_o = INIT_COLOR;

endmodule

// File: rtl/palette_ram_lut.sv
// Writable palette LUT: 2-stage lookup pipeline plus a CPU port over one RAM, self-initialised after reset.
// Optional feature macro: PAL_GRAYSCALE_EN (gray input masks the low colour bits of lookups).
module palette_ram_lut
  import palette_ram_lut_pkg::*;
(
  input logic              clk,
  input logic              rst,
  palette_ram_lut_if.slave bus
);

  logic               busy;
  logic               init_we;
  logic [ADDR_W-1:0]  init_addr;
  logic [COLOR_W-1:0] init_data;

  palette_ram_lut_init_fsm u_init (
    .clk         (clk),
    .rst         (rst),
    .busy_o      (busy),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .init_data_o (init_data)
  );

  logic               lk_acc_c, cpu_we_c, cpu_re_c;
  logic [ADDR_W-1:0]  lk_eff_c, cpu_eff_c;
  logic               wr_en_c;
  logic [ADDR_W-1:0]  wr_addr_c;
  logic [COLOR_W-1:0] wr_data_c;

  assign lk_acc_c  = bus.lk_valid & ~busy;
  assign cpu_we_c  = bus.cpu_we & ~busy;
  assign cpu_re_c  = bus.cpu_re & ~busy;
  assign lk_eff_c  = pal_eff_addr(bus.lk_fg, bus.lk_pal, bus.lk_idx);
  assign cpu_eff_c = pal_eff_addr(bus.cpu_addr[ADDR_W-1],
                                  bus.cpu_addr[ADDR_W-2 -: PAL_BITS],
                                  bus.cpu_addr[IDX_BITS-1:0]);

  // Init owns the write port while busy; CPU writes are already gated off then.
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = cpu_eff_c;
    wr_data_c = bus.cpu_wdata;
    if (init_we) begin
      wr_en_c   = ~rst;
      wr_addr_c = init_addr;
      wr_data_c = init_data;
    end else if (cpu_we_c) begin
      wr_en_c   = ~rst;
    end
  end

  logic [COLOR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_addr_c] <= wr_data_c;
  end

  // Synchronous reads see pre-write contents, giving read-before-write on same-address collisions.
  logic [COLOR_W-1:0] s1_color_q;
  always_ff @(posedge clk) begin
    s1_color_q <= mem_q[lk_eff_c];
  end

  logic       s1_valid_q, s1_transp_q;
  lk_result_t s2_q, s2_d;
`ifdef PAL_GRAYSCALE_EN
  logic       s1_gray_q;
`endif

  always_comb begin
    s2_d = '{valid: s1_valid_q, transparent: s1_transp_q, color: s1_color_q};
`ifdef PAL_GRAYSCALE_EN
    if (s1_gray_q) s2_d.color[GRAY_LSBS-1:0] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_transp_q <= 1'b0;
`ifdef PAL_GRAYSCALE_EN
      s1_gray_q   <= 1'b0;
`endif
      s2_q        <= '0;
    end else begin
      s1_valid_q  <= lk_acc_c;
      s1_transp_q <= lk_acc_c & (bus.lk_idx == '0);
`ifdef PAL_GRAYSCALE_EN
      s1_gray_q   <= bus.gray;
`endif
      s2_q        <= s2_d;
    end
  end

  logic               cpu_rvalid_q;
  logic [COLOR_W-1:0] cpu_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_re_c;
      if (cpu_re_c) cpu_rdata_q <= mem_q[cpu_eff_c];
    end
  end

  assign bus.out_valid       = s2_q.valid;
  assign bus.out_color       = s2_q.color;
  assign bus.out_transparent = s2_q.transparent;
  assign bus.cpu_rvalid      = cpu_rvalid_q;
  assign bus.cpu_rdata       = cpu_rdata_q;
  assign bus.busy            = busy;

endmodule

// File: tb/tb_palette_ram_lut.sv
// Directed, table-driven bench for palette_ram_lut with a small palette model for the random stream.
module tb_palette_ram_lut;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  palette_ram_lut_if bus ();

  palette_ram_lut dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] mdl [32];

  typedef struct {
    bit         we;
    logic [4:0] addr;
    logic [5:0] wdata;
    logic       fg;
    logic [1:0] pal;
    logic [1:0] idx;
    logic [5:0] exp_rd;
    logic [5:0] exp_color;
    bit         exp_tr;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.lk_valid  = 1'b0;
    bus.lk_fg     = 1'b0;
    bus.lk_pal    = '0;
    bus.lk_idx    = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
`ifdef PAL_GRAYSCALE_EN
    bus.gray      = 1'b0;
`endif
  endtask

  function automatic logic [4:0] teff(input logic [4:0] a);
    logic [4:0] r;
    r = a;
    if (a[1:0] == 2'b00) r = 5'd0;
    return r;
  endfunction

  // Counts busy cycles from the first post-reset sample; optionally hammers all ports meanwhile.
  task automatic run_init(input bit poke, input string tag);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if (poke) begin
        bus.cpu_we    = 1'b1;
        bus.cpu_re    = 1'b1;
        bus.cpu_addr  = 5'b0_00_01;
        bus.cpu_wdata = 6'h33;
        bus.lk_valid  = 1'b1;
        bus.lk_idx    = 2'd1;
      end
      if (bus.out_valid !== 1'b0 || bus.cpu_rvalid !== 1'b0) bad++;
      n++;
      tick();
    end
    idle();
    check({tag, "_busy_len"}, n, 32);
    check({tag, "_quiet_while_busy"}, bad, 0);
    for (int i = 0; i < 32; i++) mdl[i] = 6'h0F;
  endtask

  task automatic cpu_read(input logic [4:0] a, input logic [5:0] exp, input string name);
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = a;
    tick();
    bus.cpu_re   = 1'b0;
    check({name, "_rvalid"}, bus.cpu_rvalid, 1);
    check({name, "_rdata"}, bus.cpu_rdata, exp);
  endtask

  logic [5:0] exp_c [66];
  bit         exp_v [66];
  bit         exp_t [66];

  initial begin
    vecs[0] = '{1'b1, 5'b1_01_10, 6'h2A, 1'b1, 2'd1, 2'd2, 6'h0F, 6'h0F, 1'b0};
    vecs[1] = '{1'b0, 5'b1_01_10, 6'h00, 1'b1, 2'd1, 2'd2, 6'h2A, 6'h2A, 1'b0};
    vecs[2] = '{1'b1, 5'b1_11_00, 6'h21, 1'b0, 2'd2, 2'd0, 6'h0F, 6'h0F, 1'b1};
    vecs[3] = '{1'b0, 5'b0_00_00, 6'h00, 1'b0, 2'd2, 2'd0, 6'h21, 6'h21, 1'b1};
    vecs[4] = '{1'b1, 5'b0_10_01, 6'h16, 1'b0, 2'd2, 2'd1, 6'h0F, 6'h0F, 1'b0};
    vecs[5] = '{1'b0, 5'b1_10_11, 6'h00, 1'b0, 2'd2, 2'd1, 6'h0F, 6'h16, 1'b0};
    vecs[6] = '{1'b0, 5'b1_01_00, 6'h00, 1'b1, 2'd3, 2'd0, 6'h21, 6'h21, 1'b1};
    vecs[7] = '{1'b1, 5'b0_11_11, 6'h3F, 1'b1, 2'd1, 2'd2, 6'h0F, 6'h2A, 1'b0};
    vecs[8] = '{1'b0, 5'b0_11_11, 6'h00, 1'b0, 2'd3, 2'd3, 6'h3F, 6'h3F, 1'b0};

    idle();
    rst = 1'b1;
    tick();
    check("rst_busy", bus.busy, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_color", bus.out_color, 0);
    check("rst_out_transparent", bus.out_transparent, 0);
    check("rst_rvalid", bus.cpu_rvalid, 0);
    check("rst_rdata", bus.cpu_rdata, 0);
    rst = 1'b0;
    run_init(1'b1, "init0");

    for (int a = 0; a < 32; a++) cpu_read(5'(a), 6'h0F, "init_fill");
    tick();
    check("rdata_hold_rvalid", bus.cpu_rvalid, 0);
    check("rdata_hold_value", bus.cpu_rdata, 6'h0F);

    // Each vector: write/read/lookup issued together; read one cycle later, lookup two.
    for (int i = 0; i < 9; i++) begin
      bus.cpu_we    = vecs[i].we;
      bus.cpu_re    = 1'b1;
      bus.cpu_addr  = vecs[i].addr;
      bus.cpu_wdata = vecs[i].wdata;
      bus.lk_valid  = 1'b1;
      bus.lk_fg     = vecs[i].fg;
      bus.lk_pal    = vecs[i].pal;
      bus.lk_idx    = vecs[i].idx;
      tick();
      idle();
      check($sformatf("vec%0d_rvalid", i), bus.cpu_rvalid, 1);
      check($sformatf("vec%0d_rdata", i), bus.cpu_rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_out_valid_early", i), bus.out_valid, 0);
      tick();
      check($sformatf("vec%0d_out_valid", i), bus.out_valid, 1);
      check($sformatf("vec%0d_out_color", i), bus.out_color, vecs[i].exp_color);
      check($sformatf("vec%0d_out_transparent", i), bus.out_transparent, vecs[i].exp_tr);
      if (vecs[i].we) mdl[teff(vecs[i].addr)] = vecs[i].wdata;
    end

    // Write and lookup in the same cycle, then the same lookup on the very next cycle.
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 5'b1_00_01;
    bus.cpu_wdata = 6'h05;
    bus.lk_valid  = 1'b1;
    bus.lk_fg     = 1'b1;
    bus.lk_pal    = 2'd0;
    bus.lk_idx    = 2'd1;
    tick();
    bus.cpu_we    = 1'b0;
    tick();
    idle();
    check("rbw_old_valid", bus.out_valid, 1);
    check("rbw_old_color", bus.out_color, 6'h0F);
    tick();
    check("rbw_new_valid", bus.out_valid, 1);
    check("rbw_new_color", bus.out_color, 6'h05);
    mdl[5'b1_00_01] = 6'h05;
    tick();
    check("pipe_drained", bus.out_valid, 0);

    // Back-to-back random lookups with sporadic CPU writes against the model.
    for (int c = 0; c < 66; c++) begin
      logic [4:0] a;
      logic [4:0] wa;
      logic [5:0] wd;
      idle();
      exp_v[c] = 1'b0;
      exp_c[c] = '0;
      exp_t[c] = 1'b0;
      if (c < 64) begin
        a = 5'($urandom_range(0, 31));
        bus.lk_valid = 1'b1;
        bus.lk_fg    = a[4];
        bus.lk_pal   = a[3:2];
        bus.lk_idx   = a[1:0];
        exp_v[c] = 1'b1;
        exp_c[c] = mdl[teff(a)];
        exp_t[c] = (a[1:0] == 2'b00);
        if ($urandom_range(0, 3) == 0) begin
          wa = 5'($urandom_range(0, 31));
          wd = 6'($urandom_range(0, 63));
          bus.cpu_we    = 1'b1;
          bus.cpu_addr  = wa;
          bus.cpu_wdata = wd;
          mdl[teff(wa)] = wd;
        end
      end
      tick();
      if (c >= 1) begin
        check($sformatf("rnd%0d_out_valid", c - 1), bus.out_valid, exp_v[c-1]);
        if (exp_v[c-1]) begin
          check($sformatf("rnd%0d_out_color", c - 1), bus.out_color, exp_c[c-1]);
          check($sformatf("rnd%0d_out_transparent", c - 1), bus.out_transparent, exp_t[c-1]);
        end
      end
    end
    idle();

`ifdef PAL_GRAYSCALE_EN
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 5'b0_01_01;
    bus.cpu_wdata = 6'h27;
    tick();
    idle();
    bus.lk_valid = 1'b1;
    bus.lk_pal   = 2'd1;
    bus.lk_idx   = 2'd1;
    bus.gray     = 1'b1;
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = 5'b0_01_01;
    tick();
    idle();
    check("gray_rdata_unmasked", bus.cpu_rdata, 6'h27);
    tick();
    check("gray_out_valid", bus.out_valid, 1);
    check("gray_out_color", bus.out_color, 6'h20);
`endif

    // Reset in RUN with a lookup in flight, then reset again part-way through init.
    bus.lk_valid = 1'b1;
    bus.lk_fg    = 1'b1;
    bus.lk_pal   = 2'd1;
    bus.lk_idx   = 2'd2;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run_out_valid", bus.out_valid, 0);
    check("rst_run_busy", bus.busy, 1);
    for (int i = 0; i < 10; i++) tick();
    check("mid_init_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run_init(1'b1, "reinit");
    cpu_read(5'b1_01_10, 6'h0F, "reinit_e1_01_10");
    cpu_read(5'b0_00_00, 6'h0F, "reinit_backdrop");
    cpu_read(5'b0_00_01, 6'h0F, "reinit_busy_write_dropped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
